// File: rtl/mc_mem_pkg.sv
// Shared types, widths and the address check for the memory responder.
package mc_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    // A request is in error when misaligned or its word index falls outside the array.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
    endfunction

endpackage

// File: rtl/mc_mem_array.sv
// Word storage: synchronous write, combinational read, asynchronous clear.
module mc_mem_array
    import mc_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        we,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr,
    input  logic [DATA_W-1:0]                           wdata,
    output logic [DATA_W-1:0]                           rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/mc_mem_responder.sv
// Single-outstanding memory responder: accept, wait LATENCY cycles, hold response until taken.
module mc_mem_responder
    import mc_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic              busy
);

    localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    rsp_t               rsp;
    rsp_t               rsp_next;
    logic               req_err;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_rdata_c;

    assign req_err = addr_err(req_addr, DEPTH);

    mc_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .addr    (req_addr[IDX_W+1:2]),
        .wdata   (req_wdata),
        .rdata_c (mem_rdata_c)
    );

    // Next state, counter and response capture; the array read happens before the same-edge write.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rsp_next   = rsp;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    rsp_next.err   = req_err;
                    rsp_next.rdata = (req_err || req_write) ? '0 : mem_rdata_c;
                    mem_we         = req_write && !req_err;
                    if (LATENCY > 0) begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; status outputs are decoded from the next state so they stay registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rsp       <= rsp_next;
            req_ready <= (state_next == IDLE);
            rsp_valid <= (state_next == RESP);
            busy      <= (state_next != IDLE);
        end
    end

    assign rsp_rdata = rsp.rdata;
    assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench for mc_mem_responder: two instances (LATENCY 2 and 0) checked against a timestamp model.
module tb_mc_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int          NI    = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid [NI];
    logic        req_write [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic        req_ready [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];
    logic        rsp_ready [NI];
    logic        busy      [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mc_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .rsp_ready(rsp_ready[0]),
        .busy(busy[0])
    );

    mc_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .rsp_ready(rsp_ready[1]),
        .busy(busy[1])
    );

    function automatic int unsigned lat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is pending from acceptance until the response is taken;
    // the response becomes visible LATENCY+1 edges after the acceptance edge.
    int unsigned cyc = 0;
    logic [31:0] m_mem     [NI][DEPTH];
    bit          m_busy    [NI];
    int unsigned m_resp_at [NI];
    logic [31:0] m_rdata   [NI];
    bit          m_err     [NI];
    int unsigned n_acc     [NI];

    function automatic void model_accept(input int i);
        logic [31:0] a;
        int unsigned idx;
        a   = req_addr[i];
        idx = a / 4;
        m_err[i]   = (a % 4 != 0) || (idx >= DEPTH);
        m_rdata[i] = 32'h0;
        if (!m_err[i]) begin
            if (req_write[i]) m_mem[i][idx] = req_wdata[i];
            else              m_rdata[i]    = m_mem[i][idx];
        end
        m_resp_at[i] = cyc + 1 + lat_of(i);
        m_busy[i]    = 1'b1;
        n_acc[i]++;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                m_busy[i]  = 1'b0;
                m_rdata[i] = 32'h0;
                m_err[i]   = 1'b0;
                for (int w = 0; w < int'(DEPTH); w++) m_mem[i][w] = 32'h0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (!m_busy[i]) begin
                    if (req_valid[i]) model_accept(i);
                end else if (cyc >= m_resp_at[i] && rsp_ready[i]) begin
                    m_busy[i] = 1'b0;
                end
            end
            cyc++;
        end
    end

    // Every cycle, every output of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d.rsp_valid", i), 32'(rsp_valid[i]),
                  32'(m_busy[i] && (cyc >= m_resp_at[i])));
            check($sformatf("u%0d.req_ready", i), 32'(req_ready[i]), 32'(!m_busy[i]));
            check($sformatf("u%0d.busy", i),      32'(busy[i]),      32'(m_busy[i]));
            check($sformatf("u%0d.rsp_err", i),   32'(rsp_err[i]),   32'(m_err[i]));
            check($sformatf("u%0d.rsp_rdata", i), rsp_rdata[i],      m_rdata[i]);
        end
    end

    // One request on instance i; returns captured response and acceptance-to-valid latency.
    task automatic do_txn(input int i, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input bit wait_hs,
                          output logic [31:0] rd, output logic er, output int lat);
        int budget = 0;
        req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = addr; req_wdata[i] = wd;
        while (!req_ready[i] && budget < 50) begin
            @(posedge clk); #1; budget++;
        end
        check($sformatf("u%0d.accept_in_time", i), 32'(budget < 50), 32'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        lat = 1;
        while (!rsp_valid[i] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rd = rsp_rdata[i];
        er = rsp_err[i];
        if (wait_hs) begin
            budget = 0;
            while (rsp_valid[i] && budget < 40) begin
                @(posedge clk); #1; budget++;
            end
            check($sformatf("u%0d.handshake_in_time", i), 32'(budget < 40), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;
        int unsigned acc0;

        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;
        int unsigned acc0;

        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_addr[i]  = 32'h0; req_wdata[i] = 32'h0;
            rsp_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset.req_ready", 32'(req_ready[0]), 32'd1);
        check("reset.rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset.busy",      32'(busy[0]),      32'd0);
        check("reset.rsp_rdata", rsp_rdata[0],      32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Write then read back, first request on the first edge after release.
        do_txn(0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b1, rd, er, lat);
        check("wr08.latency", 32'(lat), 32'd3);
        check("wr08.rdata",   rd,       32'h0);
        check("wr08.err",     32'(er),  32'd0);
        do_txn(0, 1'b0, 32'h08, 32'h0, 1'b1, rd, er, lat);
        check("rd08.latency", 32'(lat), 32'd3);
        check("rd08.rdata",   rd,       32'hDEADBEEF);
        check("rd08.err",     32'(er),  32'd0);

        // Error cases and top-word boundary.
        do_txn(0, 1'b0, 32'h0A, 32'h0, 1'b1, rd, er, lat);
        check("rd0A.err",   32'(er), 32'd1);
        check("rd0A.rdata", rd,      32'h0);
        do_txn(0, 1'b0, 32'h100, 32'h0, 1'b1, rd, er, lat);
        check("rd100.err",   32'(er), 32'd1);
        check("rd100.rdata", rd,      32'h0);
        do_txn(0, 1'b1, 32'h102, 32'h55555555, 1'b1, rd, er, lat);
        check("wr102.err", 32'(er), 32'd1);
        do_txn(0, 1'b0, 32'h00, 32'h0, 1'b1, rd, er, lat);
        check("rd00.rdata", rd,      32'h0);
        check("rd00.err",   32'(er), 32'd0);
        do_txn(0, 1'b1, 32'hFC, 32'hA5A5A5A5, 1'b1, rd, er, lat);
        do_txn(0, 1'b0, 32'hFC, 32'h0, 1'b1, rd, er, lat);
        check("rdFC.rdata", rd,      32'hA5A5A5A5);
        check("rdFC.err",   32'(er), 32'd0);

        // Response held while the requester stalls.
        rsp_ready[0] = 1'b0;
        do_txn(0, 1'b0, 32'h08, 32'h0, 1'b0, rd, er, lat);
        check("hold.latency", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold.rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("hold.rsp_rdata", rsp_rdata[0],      32'hDEADBEEF);
            check("hold.req_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("hold.release_valid", 32'(rsp_valid[0]), 32'd0);
        check("hold.release_ready", 32'(req_ready[0]), 32'd1);

        // Zero-latency instance, back-to-back write/read.
        do_txn(1, 1'b1, 32'h10, 32'hCAFEF00D, 1'b1, rd, er, lat);
        check("l0.wr.latency", 32'(lat), 32'd1);
        do_txn(1, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
        check("l0.rd.latency", 32'(lat), 32'd1);
        check("l0.rd.rdata",   rd,       32'hCAFEF00D);
        do_txn(1, 1'b0, 32'h103, 32'h0, 1'b1, rd, er, lat);
        check("l0.rd103.err", 32'(er), 32'd1);

        // Reset during WAIT aborts the write and clears memory.
        req_valid[0] = 1'b1; req_write[0] = 1'b1;
        req_addr[0]  = 32'h04; req_wdata[0] = 32'h12345678;
        check("abort.ready_before", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("abort.busy_in_wait", 32'(busy[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort.rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("abort.busy",      32'(busy[0]),      32'd0);
        check("abort.req_ready", 32'(req_ready[0]), 32'd1);
        check("abort.rsp_rdata", rsp_rdata[0],      32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        do_txn(0, 1'b0, 32'h04, 32'h0, 1'b1, rd, er, lat);
        check("abort.rd04", rd, 32'h0);
        do_txn(0, 1'b0, 32'h08, 32'h0, 1'b1, rd, er, lat);
        check("abort.rd08", rd, 32'h0);
        do_txn(1, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
        check("abort.l0.rd10", rd, 32'h0);

        // Request held valid continuously: one acceptance per 4-cycle transaction.
        acc  = 0;
        acc0 = n_acc[0];
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h00;
        for (int k = 0; k < 12; k++) begin
            if (req_ready[0]) acc++;
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        check("hold_valid.dut_accepts",   32'(acc),            32'd3);
        check("hold_valid.model_accepts", n_acc[0] - acc0,     32'd3);
        for (int k = 0; k < 10 && busy[0]; k++) begin
            @(posedge clk); #1;
        end
        check("hold_valid.idle", 32'(busy[0]), 32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_mem_responder.md
MC_MEM_RESPONDER -- requirements
Module: mc_mem_responder

Interface
REQ-001 The block SHALL use a single clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter DEPTH, default 64, SHALL give the number of 32-bit words stored; it SHALL be a power of two, at most 1024.
REQ-003 Parameter LATENCY, default 2, SHALL give the number of wait cycles between request acceptance and response; legal range is 0..15.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  requester has a valid request.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_ready  output  1  responder can accept a request.
REQ-011 rsp_valid  output  1  response is valid.
REQ-012 rsp_rdata  output  32  read data (0 for writes and errors).
REQ-013 rsp_err  output  1  request was misaligned or out of range.
REQ-014 rsp_ready  input  1  requester accepts the response.
REQ-015 busy  output  1  state is not IDLE, for test observation.

Function
REQ-016 The state machine SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-018 On acceptance, next state SHALL be WAIT with the counter loaded to LATENCY-1 if LATENCY>0, else RESP.
REQ-019 In WAIT the counter SHALL decrement each cycle, and the state SHALL move to RESP on the edge where the counter is 0.
REQ-020 In RESP, rsp_valid SHALL be 1 with rsp_rdata and rsp_err held stable until the edge where rsp_ready=1, and then the state SHALL return to IDLE.
REQ-021 Acceptance-to-rsp_valid latency SHALL be exactly LATENCY+1 cycles; rsp_valid SHALL be 0 outside RESP.
REQ-022 A request SHALL be erroneous if req_addr[1:0]!=0 or word index req_addr[31:2] >= DEPTH.
REQ-023 An erroneous request SHALL set rsp_err=1, give rsp_rdata=0, and leave the memory unmodified.
REQ-024 A valid write SHALL update mem[req_addr[31:2]] on the acceptance edge, and its response SHALL carry rsp_rdata=0 and rsp_err=0.
REQ-025 A valid read SHALL capture mem[index] on the acceptance edge into the response register.
REQ-026 A read accepted in the cycle after a write to the same word SHALL return the new data.
REQ-027 If req_valid=1 while not IDLE, the block SHALL ignore the request; the requester holds it.
REQ-028 The response register SHALL change only on acceptance edges, and the counter only in WAIT or on acceptance.
REQ-029 If rsp_ready is already 1 on the first RESP cycle, the response SHALL still be visible for one full cycle.

Reset
REQ-030 While reset=0, the block SHALL force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, req_ready 1, and all memory words 0.
REQ-031 Reset asserted in WAIT or RESP SHALL abort the transaction without a response, and any write already accepted SHALL be cleared by the memory reset.
REQ-032 Deassertion of reset SHALL be synchronous to clk, and the first request SHALL be acceptable on the first rising edge after deassertion.

Structure
REQ-033 A shared package mc_mem_pkg SHALL hold the state enum (IDLE, WAIT, RESP), the width constants (data 32, address 32, counter 4) and the error-check function.
REQ-034 Storage SHALL be a sub-module mc_mem_array (synchronous write, combinational read, async-clear).
REQ-035 The FSM, counter and response register SHALL reside in mc_mem_responder.

Verification
REQ-036 Reset, then with LATENCY=2 write 0xDEADBEEF to 0x08, then read 0x08 -> rsp_valid 3 cycles after each acceptance, and the read gives rsp_rdata=0xDEADBEEF with rsp_err=0.
REQ-037 Read 0x0A (misaligned), then read 0x100 with DEPTH=64 -> rsp_err=1 and rsp_rdata=0 for both; a following read of 0x00 gives 0.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; rsp_ready=1 -> IDLE on the next edge.
REQ-039 With LATENCY=0, write then read back-to-back with rsp_ready=1 -> each response one cycle after acceptance, and the read returns the written data.
REQ-040 Write 0x12345678 to 0x04, assert reset during WAIT -> outputs zero immediately; after release, read 0x04 returns 0.
REQ-041 Drive req_valid=1 continuously during WAIT and RESP -> exactly one acceptance per transaction, with req_ready=1 only in IDLE.
